// File: rtl/apu_pulse_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : apu_pulse_sweep
//  Description : Pulse (square) tone channel: duty generator, length counter,
//                volume envelope and frequency sweep, all on clockgb.
//  Revision    : 1.0 - initial release
// ============================================================================
module apu_pulse_sweep #(
    parameter int FREQ_WIDTH  = 11,
    parameter int LEN_WIDTH   = 6,
    parameter int VOL_WIDTH   = 4,
    parameter int TIMER_SHIFT = 2,
    parameter int SWEEP_EN    = 1
) (
    input  logic                 clockgb,
    input  logic                 resetn,
    input  logic                 frame_tick,
    input  logic [2:0]           frame_step,
    input  logic                 wr_sweep,
    input  logic                 wr_duty_len,
    input  logic                 wr_env,
    input  logic                 wr_freq_lo,
    input  logic                 wr_freq_hi,
    input  logic [7:0]           wdata,
    output logic [VOL_WIDTH-1:0] sample,
    output logic                 active
);

    localparam int c_tmr_w = FREQ_WIDTH + 1 + TIMER_SHIFT;
    localparam logic [FREQ_WIDTH:0]  c_freq_span = {1'b1, {FREQ_WIDTH{1'b0}}};
    localparam logic [LEN_WIDTH:0]   c_len_full  = {1'b1, {LEN_WIDTH{1'b0}}};
    localparam logic [LEN_WIDTH:0]   c_len_one   = {{LEN_WIDTH{1'b0}}, 1'b1};
    localparam logic [VOL_WIDTH-1:0] c_vol_max   = '1;

    // Clocks per duty step minus one: the counter spends one cycle at zero.
    function automatic logic [c_tmr_w-1:0] f_step_len(input logic [FREQ_WIDTH-1:0] f);
        logic [c_tmr_w-1:0] span;
        span = c_tmr_w'(c_freq_span) - c_tmr_w'(f);
        return (span << TIMER_SHIFT) - c_tmr_w'(1);
    endfunction

    logic [FREQ_WIDTH-1:0] r_freq;
    logic [FREQ_WIDTH-1:0] r_shadow;
    logic [1:0]            r_duty;
    logic                  r_len_en;
    logic [LEN_WIDTH:0]    r_len_cnt;
    logic [3:0]            r_env_init;
    logic                  r_env_up;
    logic [2:0]            r_env_per;
    logic [2:0]            r_env_cnt;
    logic [VOL_WIDTH-1:0]  r_vol;
    logic [2:0]            r_sw_per;
    logic                  r_sw_neg;
    logic [2:0]            r_sw_shift;
    logic [3:0]            r_sw_timer;
    logic [2:0]            r_pos;
    logic [c_tmr_w-1:0]    r_timer;
    logic                  r_active;

    logic                  w_trigger;
    logic                  w_frame;
    logic                  w_len_clk;
    logic                  w_sw_clk;
    logic                  w_env_clk;
    logic                  w_dac_on;
    logic                  w_sweep_wr;
    logic [FREQ_WIDTH-1:0] w_freq_trig;
    logic [FREQ_WIDTH:0]   w_sw_cur;
    logic [FREQ_WIDTH:0]   w_sw_new;
    logic [FREQ_WIDTH:0]   w_sw_new_ext;
    logic [FREQ_WIDTH:0]   w_sw_new2;
    logic [FREQ_WIDTH:0]   w_tr_cur;
    logic [FREQ_WIDTH:0]   w_tr_sum;
    logic [3:0]            w_sw_per_eff;
    logic                  w_sw_fire;
    logic                  w_sw_ovf;
    logic                  w_sw_commit;
    logic                  w_sw_kill;
    logic                  w_tr_kill;
    logic                  w_len_kill;
    logic [7:0]            w_pattern;

    // A trigger owns the cycle: frame events coinciding with it are dropped.
    assign w_trigger   = wr_freq_hi & wdata[7];
    assign w_frame     = frame_tick & ~w_trigger;
    assign w_len_clk   = w_frame & ~frame_step[0];
    assign w_sw_clk    = w_frame & (frame_step[1:0] == 2'b10);
    assign w_env_clk   = w_frame & (frame_step == 3'd7);
    assign w_dac_on    = (r_env_init != 4'd0) | r_env_up;
    assign w_sweep_wr  = wr_sweep & (SWEEP_EN != 0);
    assign w_freq_trig = {wdata[FREQ_WIDTH-9:0], r_freq[7:0]};

    // Sweep arithmetic is one bit wider so an add overflow shows up in the MSB.
    assign w_sw_cur     = {1'b0, r_shadow};
    assign w_sw_new     = r_sw_neg ? (w_sw_cur - (w_sw_cur >> r_sw_shift))
                                   : (w_sw_cur + (w_sw_cur >> r_sw_shift));
    assign w_sw_new_ext = {1'b0, w_sw_new[FREQ_WIDTH-1:0]};
    assign w_sw_new2    = w_sw_new_ext + (w_sw_new_ext >> r_sw_shift);
    assign w_sw_per_eff = (r_sw_per == 3'd0) ? 4'd8 : {1'b0, r_sw_per};
    assign w_sw_fire    = w_sw_clk & (r_sw_timer <= 4'd1) & (r_sw_per != 3'd0);
    assign w_sw_ovf     = ~r_sw_neg & w_sw_new[FREQ_WIDTH];
    assign w_sw_commit  = w_sw_fire & ~w_sw_ovf & (r_sw_shift != 3'd0);
    assign w_sw_kill    = (SWEEP_EN != 0) & w_sw_fire &
                          (w_sw_ovf | ((r_sw_shift != 3'd0) & ~r_sw_neg & w_sw_new2[FREQ_WIDTH]));

    // Immediate overflow check on trigger uses the freshly written high bits.
    assign w_tr_cur  = {1'b0, w_freq_trig};
    assign w_tr_sum  = w_tr_cur + (w_tr_cur >> r_sw_shift);
    assign w_tr_kill = (SWEEP_EN != 0) & (r_sw_shift != 3'd0) & ~r_sw_neg & w_tr_sum[FREQ_WIDTH];

    assign w_len_kill = w_len_clk & r_len_en & (r_len_cnt == c_len_one);

    // Duty waveform table, bit index = duty position.
    always_comb begin
        w_pattern = 8'b1000_0000;
        case (r_duty)
            2'd0:    w_pattern = 8'b1000_0000;
            2'd1:    w_pattern = 8'b1000_0001;
            2'd2:    w_pattern = 8'b1110_0001;
            default: w_pattern = 8'b0111_1110;
        endcase
    end

    assign active = r_active & w_dac_on;
    assign sample = (active & w_pattern[r_pos]) ? r_vol : '0;

    // CPU-visible configuration fields.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            r_duty     <= 2'd0;
            r_len_en   <= 1'b0;
            r_env_init <= 4'd0;
            r_env_up   <= 1'b0;
            r_env_per  <= 3'd0;
            r_sw_per   <= 3'd0;
            r_sw_neg   <= 1'b0;
            r_sw_shift <= 3'd0;
        end else begin
            if (wr_duty_len) r_duty <= wdata[7:6];
            if (wr_freq_hi)  r_len_en <= wdata[6];
            if (wr_env) begin
                r_env_init <= wdata[7:4];
                r_env_up   <= wdata[3];
                r_env_per  <= wdata[2:0];
            end
            if (w_sweep_wr) begin
                r_sw_per   <= wdata[6:4];
                r_sw_neg   <= wdata[3];
                r_sw_shift <= wdata[2:0];
            end
        end
    end

    // Duty timer: steps the waveform position each time the counter expires.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
            r_pos   <= 3'd0;
        end else if (w_trigger) begin
            r_timer <= f_step_len(w_freq_trig);
            r_pos   <= 3'd0;
        end else if (r_timer == '0) begin
            r_timer <= f_step_len(r_freq);
            r_pos   <= r_pos + 3'd1;
        end else begin
            r_timer <= r_timer - 1'b1;
        end
    end

    // Length counter: a register write overrides any same-cycle decrement.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            r_len_cnt <= '0;
        end else if (wr_duty_len) begin
            r_len_cnt <= c_len_full - {1'b0, wdata[LEN_WIDTH-1:0]};
        end else if (w_trigger) begin
            if (r_len_cnt == '0) r_len_cnt <= c_len_full;
        end else if (w_len_clk && r_len_en && (r_len_cnt != '0)) begin
            r_len_cnt <= r_len_cnt - 1'b1;
        end
    end

    // Volume envelope with saturation at both ends.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            r_vol     <= '0;
            r_env_cnt <= 3'd0;
        end else if (w_trigger) begin
            r_vol     <= VOL_WIDTH'(r_env_init);
            r_env_cnt <= r_env_per;
        end else if (w_env_clk && (r_env_per != 3'd0)) begin
            if (r_env_cnt <= 3'd1) begin
                r_env_cnt <= r_env_per;
                if (r_env_up && (r_vol != c_vol_max))      r_vol <= r_vol + 1'b1;
                else if (!r_env_up && (r_vol != '0))       r_vol <= r_vol - 1'b1;
            end else begin
                r_env_cnt <= r_env_cnt - 3'd1;
            end
        end
    end

    // Sweep timer, shadow and frequency; CPU byte writes land after any sweep update.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            r_sw_timer <= 4'd0;
            r_shadow   <= '0;
            r_freq     <= '0;
        end else begin
            if (w_trigger) begin
                r_shadow   <= w_freq_trig;
                r_sw_timer <= w_sw_per_eff;
            end else if (w_sw_clk) begin
                if (r_sw_timer <= 4'd1) r_sw_timer <= w_sw_per_eff;
                else                    r_sw_timer <= r_sw_timer - 4'd1;
                if (w_sw_commit) begin
                    r_shadow <= w_sw_new[FREQ_WIDTH-1:0];
                    r_freq   <= w_sw_new[FREQ_WIDTH-1:0];
                end
            end
            if (wr_freq_lo) r_freq[7:0] <= wdata;
            if (wr_freq_hi) r_freq[FREQ_WIDTH-1:8] <= wdata[FREQ_WIDTH-9:0];
        end
    end

    // Channel enable: set by trigger, cleared by DAC off, length expiry or sweep overflow.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            r_active <= 1'b0;
        end else if (w_trigger) begin
            r_active <= w_dac_on & ~w_tr_kill;
        end else if (!w_dac_on || w_len_kill || w_sw_kill) begin
            r_active <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apu_pulse_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apu_pulse_sweep
//  Description : Scoreboard bench for apu_pulse_sweep against a behavioural
//                channel model (directed scenarios plus random traffic).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apu_pulse_sweep;

    localparam int K_NONE = 0, K_SWEEP = 1, K_DLEN = 2, K_ENV = 3, K_FLO = 4, K_FHI = 5;

    logic       clockgb = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic [2:0] frame_step = 3'd0;
    logic       wr_sweep = 1'b0, wr_duty_len = 1'b0, wr_env = 1'b0;
    logic       wr_freq_lo = 1'b0, wr_freq_hi = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic [3:0] sample;
    logic       active;

    apu_pulse_sweep #(
        .FREQ_WIDTH(11), .LEN_WIDTH(6), .VOL_WIDTH(4), .TIMER_SHIFT(2), .SWEEP_EN(1)
    ) dut (
        .clockgb(clockgb), .resetn(resetn), .frame_tick(frame_tick), .frame_step(frame_step),
        .wr_sweep(wr_sweep), .wr_duty_len(wr_duty_len), .wr_env(wr_env),
        .wr_freq_lo(wr_freq_lo), .wr_freq_hi(wr_freq_hi), .wdata(wdata),
        .sample(sample), .active(active)
    );

    always #5 clockgb = ~clockgb;

    typedef struct { int s; int a; } exp_t;
    exp_t  q_exp[$];
    string q_name[$];
    exp_t  last_exp;
    int    n_tests = 0;
    int    n_fail = 0;

    // Behavioural channel state, plain integers.
    int m_freq, m_duty, m_len_en, m_len, m_ev0, m_eup, m_eper, m_vol, m_ecnt;
    int m_sper, m_sneg, m_ssh, m_stmr, m_shadow, m_pos, m_elapsed, m_steplen, m_act;
    string waves[4] = '{"00000001", "10000001", "10000111", "01111110"};

    function automatic int step_clocks(input int f);
        return (2048 - f) * 4;
    endfunction

    task automatic model_reset();
        m_freq = 0; m_duty = 0; m_len_en = 0; m_len = 0; m_ev0 = 0; m_eup = 0; m_eper = 0;
        m_vol = 0; m_ecnt = 0; m_sper = 0; m_sneg = 0; m_ssh = 0; m_stmr = 0; m_shadow = 0;
        m_pos = 0; m_elapsed = 0; m_steplen = 1; m_act = 0;
    endtask

    task automatic model_step(input int kind, input int d, input bit tk, input int st, output exp_t e);
        bit trig, dac_old, lenclk, swclk, envclk;
        int nf, nw;
        trig    = (kind == K_FHI) && (((d >> 7) & 1) == 1);
        dac_old = (m_ev0 != 0) || (m_eup != 0);
        lenclk  = tk && !trig && (st % 2 == 0);
        swclk   = tk && !trig && (st == 2 || st == 6);
        envclk  = tk && !trig && (st == 7);
        // waveform position
        if (trig) begin
            nf = (m_freq & 255) | ((d & 7) << 8);
            m_pos = 0; m_elapsed = 0; m_steplen = step_clocks(nf);
        end else begin
            m_elapsed++;
            if (m_elapsed == m_steplen) begin
                m_pos = (m_pos + 1) % 8; m_elapsed = 0; m_steplen = step_clocks(m_freq);
            end
        end
        if (lenclk && m_len_en != 0 && m_len != 0) begin
            m_len--;
            if (m_len == 0) m_act = 0;
        end
        if (envclk && m_eper != 0) begin
            m_ecnt--;
            if (m_ecnt <= 0) begin
                m_ecnt = m_eper;
                if (m_eup != 0 && m_vol < 15) m_vol++;
                else if (m_eup == 0 && m_vol > 0) m_vol--;
            end
        end
        if (swclk) begin
            m_stmr--;
            if (m_stmr <= 0) begin
                m_stmr = (m_sper == 0) ? 8 : m_sper;
                if (m_sper != 0) begin
                    nw = (m_sneg != 0) ? m_shadow - (m_shadow >> m_ssh) : m_shadow + (m_shadow >> m_ssh);
                    if (nw >= 2048) m_act = 0;
                    else if (m_ssh != 0) begin
                        m_shadow = nw; m_freq = nw;
                        if (m_sneg == 0 && nw + (nw >> m_ssh) >= 2048) m_act = 0;
                    end
                end
            end
        end
        case (kind)
            K_SWEEP: begin m_sper = (d >> 4) & 7; m_sneg = (d >> 3) & 1; m_ssh = d & 7; end
            K_DLEN:  begin m_duty = (d >> 6) & 3; m_len = 64 - (d & 63); end
            K_ENV:   begin m_ev0 = (d >> 4) & 15; m_eup = (d >> 3) & 1; m_eper = d & 7; end
            K_FLO:   m_freq = (m_freq & 'h700) | (d & 255);
            K_FHI:   begin m_freq = (m_freq & 255) | ((d & 7) << 8); m_len_en = (d >> 6) & 1; end
            default: ;
        endcase
        if (trig) begin
            m_act = dac_old ? 1 : 0;
            if (m_len == 0) m_len = 64;
            m_vol = m_ev0; m_ecnt = m_eper; m_shadow = m_freq;
            m_stmr = (m_sper == 0) ? 8 : m_sper;
            if (m_ssh != 0 && m_sneg == 0 && m_shadow + (m_shadow >> m_ssh) >= 2048) m_act = 0;
        end else if (!dac_old) begin
            m_act = 0;
        end
        e.a = (m_act != 0 && (m_ev0 != 0 || m_eup != 0)) ? 1 : 0;
        e.s = (e.a == 1 && waves[m_duty][m_pos] == 8'h31) ? m_vol : 0;
    endtask

    // One clock of stimulus: drive at the falling edge, queue the post-edge expectation.
    task automatic cycle(input int kind, input int d, input bit tk, input int st, input string nm);
        exp_t e;
        @(negedge clockgb);
        wr_sweep    = (kind == K_SWEEP);
        wr_duty_len = (kind == K_DLEN);
        wr_env      = (kind == K_ENV);
        wr_freq_lo  = (kind == K_FLO);
        wr_freq_hi  = (kind == K_FHI);
        wdata       = 8'(d);
        frame_tick  = tk;
        frame_step  = 3'(st);
        model_step(kind, d, tk, st, e);
        last_exp = e;
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) cycle(K_NONE, 0, 1'b0, 0, nm);
    endtask

    task automatic check(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: compares DUT outputs one step after each rising edge.
    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clockgb);
            #1;
            if (q_exp.size() > 0) begin
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                n_tests++;
                if (int'(sample) != e.s || int'(active) != e.a) begin
                    n_fail++;
                    $display("FAIL %s @%0t: sample=%0d active=%0d, expected sample=%0d active=%0d",
                             nm, $time, sample, active, e.s, e.a);
                end
            end
        end
    end

    initial begin : stim
        int fstep, kind, d, r;
        bit tk;
        model_reset();
        #2;
        check("reset_sample", int'(sample), 0);
        check("reset_active", int'(active), 0);
        @(posedge clockgb); #2 resetn = 1'b1;

        // duty 2, 4-clock steps
        cycle(K_FLO, 'hFF, 0, 0, "duty_setup");
        cycle(K_DLEN, 'h80, 0, 0, "duty_setup");
        cycle(K_ENV, 'hF0, 0, 0, "duty_setup");
        cycle(K_FHI, 'h87, 0, 0, "duty_trigger");
        idle(40, "duty_wave");

        // length expiry after two length clocks
        cycle(K_DLEN, 'hBE, 0, 0, "len_setup");
        cycle(K_FHI, 'hC7, 0, 0, "len_trigger");
        idle(3, "len_run");
        cycle(K_NONE, 0, 1, 0, "len_tick0");
        idle(3, "len_run");
        cycle(K_NONE, 0, 1, 2, "len_tick2");
        idle(3, "len_off");
        cycle(K_NONE, 0, 1, 4, "len_tick4");
        idle(3, "len_off");

        // envelope ramp to saturation, then DAC off
        cycle(K_ENV, 'h49, 0, 0, "env_setup");
        cycle(K_DLEN, 'hC0, 0, 0, "env_setup");
        cycle(K_FHI, 'h87, 0, 0, "env_trigger");
        for (int i = 0; i < 13; i++) begin
            idle(5, "env_ramp");
            cycle(K_NONE, 0, 1, 7, "env_tick7");
        end
        idle(5, "env_hold");
        cycle(K_ENV, 'h00, 0, 0, "dac_off");
        cycle(K_FHI, 'h87, 0, 0, "dac_off_trigger");
        idle(5, "dac_off_idle");

        // sweep add overflow on trigger
        cycle(K_ENV, 'hF0, 0, 0, "swadd_setup");
        cycle(K_FLO, 'h00, 0, 0, "swadd_setup");
        cycle(K_SWEEP, 'h11, 0, 0, "swadd_setup");
        cycle(K_FHI, 'h87, 0, 0, "swadd_trigger");
        idle(3, "swadd_off");

        // sweep subtract: 0x400 -> 0x300 -> 0x240
        cycle(K_SWEEP, 'h1A, 0, 0, "swsub_setup");
        cycle(K_FHI, 'h84, 0, 0, "swsub_trigger");
        idle(100, "swsub_run");
        cycle(K_NONE, 0, 1, 2, "swsub_tick2");
        idle(100, "swsub_run");
        cycle(K_NONE, 0, 1, 6, "swsub_tick6");
        idle(11000, "swsub_run");

        // trigger beats a coincident envelope clock
        cycle(K_FLO, 'hFF, 0, 0, "trigenv_setup");
        cycle(K_ENV, 'h99, 0, 0, "trigenv_setup");
        cycle(K_FHI, 'h87, 1, 7, "trigenv_trigger");
        idle(12, "trigenv_run");

        // asynchronous reset mid-note
        @(posedge clockgb); #2;
        check("pre_reset_active", int'(active), last_exp.a);
        resetn = 1'b0;
        #1;
        check("async_reset_sample", int'(sample), 0);
        check("async_reset_active", int'(active), 0);
        @(negedge clockgb);
        wr_freq_hi = 1'b0; frame_tick = 1'b0; wdata = 8'd0;
        @(posedge clockgb); #2 resetn = 1'b1;
        model_reset();

        // random traffic
        fstep = 0;
        for (int i = 0; i < 5000; i++) begin
            r = $urandom_range(0, 99);
            d = $urandom_range(0, 255);
            if (r < 2)       kind = K_SWEEP;
            else if (r < 4)  kind = K_DLEN;
            else if (r < 6)  kind = K_ENV;
            else if (r < 8)  kind = K_FLO;
            else if (r < 11) begin
                kind = K_FHI;
                if ($urandom_range(0, 3) != 0) d = (d & 'hC0) | 7;
            end else kind = K_NONE;
            tk = (i % 8 == 0);
            cycle(kind, d, tk, fstep, "random");
            if (tk) fstep = (fstep + 1) % 8;
        end
        idle(2, "random_tail");
        @(posedge clockgb); #3;
        check("scoreboard_drained", q_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apu_pulse_sweep.md
Name: apu_pulse_sweep

Overview:
- Parametrised pulse (square) tone channel for the APU: duty generator, length counter, volume envelope and frequency sweep.
- Sweep is new behaviour; previous channels had none.
- All state runs on the single clockgb domain. Frame-sequencer events arrive as qualified enables (frame_tick + frame_step) instead of derived 256/128/64 Hz clocks.
- The APU instantiates one copy per pulse channel and mixes the sample output.

Parameters:
- FREQ_WIDTH, 11: width of the frequency register and sweep shadow.
- LEN_WIDTH, 6: width of the length counter. Full length = 2^LEN_WIDTH.
- VOL_WIDTH, 4: envelope volume width. Max volume = 2^VOL_WIDTH-1.
- TIMER_SHIFT, 2: prescale. Duty step period = (2^FREQ_WIDTH - freq) << TIMER_SHIFT clocks.
- SWEEP_EN, 1: 0 removes sweep logic. Sweep writes are then ignored and there is no overflow check.

Ports:
- clockgb, input, 1: GB system clock.
- resetn, input, 1: asynchronous active-low reset.
- frame_tick, input, 1: one-cycle pulse at 512 Hz from the frame sequencer.
- frame_step, input, 3: sequencer step number; valid when frame_tick=1.
- wr_sweep, input, 1: write sweep register. wdata[6:4] = period, [3] = negate, [2:0] = shift.
- wr_duty_len, input, 1: write duty/length. wdata[7:6] = duty, [LEN_WIDTH-1:0] = length load.
- wr_env, input, 1: write envelope. wdata[7:4] = initial volume, [3] = up, [2:0] = period.
- wr_freq_lo, input, 1: write freq[7:0].
- wr_freq_hi, input, 1: write freq[FREQ_WIDTH-1:8]. wdata[6] = length enable, wdata[7] = trigger.
- wdata, input, 8: write data. Sampled when any wr_* is high.
- sample, output, VOL_WIDTH: current output level.
- active, output, 1: channel enabled (feeds NR52 status bit).

Behaviour:
- Reset: all registers 0; sample=0; active=0; duty position 0; timer 0.
- At most one wr_* is high per cycle. Writes take effect on the next edge.
- Duty timer:
  - Down-counter. At 0 it reloads (2^FREQ_WIDTH - freq) << TIMER_SHIFT and advances the 3-bit duty position (wraps 7->0).
  - Duty patterns, position 0 first: 00000001, 10000001, 10000111, 01111110.
- sample = volume when active and the pattern bit is 1; else 0.
- Frame events, only when frame_tick=1:
  - Steps 0, 2, 4, 6: length clock.
  - Steps 2, 6: sweep clock.
  - Step 7: envelope clock.
- Length:
  - wr_duty_len loads counter = 2^LEN_WIDTH - load, computed modulo 2^(LEN_WIDTH+1). Load 0 gives the full count 2^LEN_WIDTH.
  - On a length clock with length enable=1 and counter≠0: decrement. Reaching 0 clears active.
- Envelope:
  - A period counter reloads from the period field.
  - On an envelope clock with period≠0: decrement the counter. At 0, reload it and step volume ±1, saturating at 0 and at max.
  - Period 0 freezes the volume.
- DAC: initial volume=0 and up=0 means the DAC is off. active is forced to 0 and triggers do not set it.
- Sweep:
  - Sweep timer reloads from the period field, with 0 treated as 8.
  - On a sweep clock: decrement the timer. At 0, reload it; if period≠0, compute new = shadow ± (shadow >> shift).
  - Overflow (new ≥ 2^FREQ_WIDTH on the add path) clears active.
  - Else, if shift≠0: shadow=new and freq=new, then run a second overflow check with the same rule, which can also clear active.
  - The subtract path never overflows. Arithmetic uses FREQ_WIDTH+1 bits.
- Trigger (wr_freq_hi with wdata[7]=1), all in the same cycle:
  - active=1 (unless the DAC is off).
  - Duty timer reloads; duty position=0.
  - If length counter=0, load the full count.
  - Volume and envelope counter load from the envelope register.
  - shadow=freq (using the newly written high bits).
  - Sweep timer reloads.
  - If shift≠0, an immediate overflow check runs and may clear active.
- Simultaneous trigger and frame_tick: the trigger wins. The frame event is dropped for this channel that cycle.
- Write freq while active without trigger: the new period is used at the next timer reload; no glitch reset.
- resetn low mid-note: everything returns to reset values immediately (async).

Test Plan:
- Duty/period: freq=0x7FF, duty=2, env vol=15 up=0 period=0, trigger → timer period 4 clocks; sample sequence 15,0,0,0,0,15,15,15 repeating every 32 clocks.
- Length: len load=62, length enable=1, trigger, issue 2 length-clock ticks (steps 0, 2) → active drops after the 2nd tick; the 3rd tick causes no change.
- Envelope: vol=4 up=1 period=1 → volume 5,6,...,15 on successive step-7 ticks, then holds at 15. Then vol=0 up=0, trigger → active stays 0.
- Sweep add overflow: freq=0x700, shift=1, up (negate=0), period=1, trigger → immediate check 0x700+0x380=0xA80 > 0x7FF, so active=0 in the cycle after the trigger.
- Sweep subtract: freq=0x400, negate=1, shift=2, period=1 → freq goes 0x300 then 0x240 on successive step-2/6 ticks; active stays 1.
- Trigger and frame_tick step 7 in the same cycle → volume equals the initial value with no envelope step. Then assert resetn=0 mid-note → sample=0 and active=0 asynchronously.
